// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master issues operands; the slave (the subtractor) returns the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B - Bin over WIDTH cycles using one
// full-subtractor cell and a borrow flip-flop, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] d_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a0;
  logic             b0;
  logic             d;
  logic             br_next;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign a0      = a_sr[0];
  assign b0      = b_sr[0];
  assign d       = a0 ^ b0 ^ br;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign d_next  = {d, d_sr[WIDTH-1:1]};

  assign bus.busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.done <= 1'b0;
      bus.D    <= '0;
      bus.Bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr  <= bus.A;
            b_sr  <= bus.B;
            br    <= bus.Bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_next;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          // The last bit lands straight in the result so D is valid with done.
          if (cnt == LAST) begin
            bus.D    <= d_next;
            bus.Bout <= br_next;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected {Bout, D},
// a negedge monitor pops and compares whenever done is presented.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         errors = 0;
  int         doneCount = 0;
  logic [8:0] expq[$];
  logic [8:0] monExp;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      doneCount++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected done: got D=0x%0h Bout=%0b, expected no result",
                 bus.D, bus.Bout);
      end else begin
        monExp = expq.pop_front();
        checkOutput("result D", 32'(bus.D), 32'(monExp[7:0]));
        checkOutput("result Bout", 32'(bus.Bout), 32'(monExp[8]));
      end
    end
  end

  // Issue one operation and verify its handshake timing.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                               input logic [7:0] expD, input logic expB);
    int cyc;
    int busyCnt;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    expq.push_back({expB, expD});
    cyc     = 0;
    busyCnt = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) bus.start = 1'b0;
      cyc++;
      if (bus.busy === 1'b1) busyCnt++;
    end while (bus.done !== 1'b1 && cyc < 40);
    if (bus.done !== 1'b1) checkOutput("done timeout", 32'd0, 32'd1);
    checkOutput("done latency", 32'(cyc), 32'd9);
    checkOutput("busy cycles", 32'(busyCnt), 32'd8);
    @(negedge clk);
    checkOutput("done pulse width", 32'(bus.done), 32'd0);
    checkOutput("busy after done", 32'(bus.busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         base;
    int         cyc;
    logic       seen;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    logic [8:0] rexp;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    rst_n     = 1'b0;

    #12;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset D", 32'(bus.D), 32'd0);
    checkOutput("reset Bout", 32'(bus.Bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic and boundary vectors");
    applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    applyStimulus(8'h80, 8'h80, 1'b1, 8'hFF, 1'b1);
    applyStimulus(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    applyStimulus(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

    $display("[TB] start ignored during RUN and DONE");
    base = doneCount;
    @(negedge clk);
    bus.A     = 8'h5A;
    bus.B     = 8'h3C;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    expq.push_back({1'b0, 8'h1E});
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (cyc == 3) begin
        bus.A     = 8'h01;
        bus.B     = 8'h02;
        bus.start = 1'b1;
      end
      if (cyc == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checkOutput("ignore done seen", 32'(seen), 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("ignore done pulse", 32'(bus.done), 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("ignore done count", 32'(doneCount - base), 32'd1);
    checkOutput("ignore idle busy", 32'(bus.busy), 32'd0);
    checkOutput("ignore D hold", 32'(bus.D), 32'h1E);

    $display("[TB] asynchronous reset mid-run");
    base = doneCount;
    @(negedge clk);
    bus.A     = 8'h33;
    bus.B     = 8'h11;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy before reset", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(bus.busy), 32'd0);
    checkOutput("async reset done", 32'(bus.done), 32'd0);
    checkOutput("async reset D", 32'(bus.D), 32'd0);
    checkOutput("async reset Bout", 32'(bus.Bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("no done after abort", 32'(doneCount - base), 32'd0);
    applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);

    $display("[TB] back-to-back random operations");
    base = doneCount;
    @(negedge clk);
    ra   = 8'($urandom_range(0, 255));
    rb   = 8'($urandom_range(0, 255));
    rbin = 1'($urandom_range(0, 1));
    rexp = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
    bus.A     = ra;
    bus.B     = rb;
    bus.Bin   = rbin;
    bus.start = 1'b1;
    expq.push_back(rexp);
    for (int n = 0; n < 1000; n++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (bus.done !== 1'b1 && cyc < 40);
      if (bus.done !== 1'b1) begin
        checkOutput("b2b done timeout", 32'd0, 32'd1);
        break;
      end
      checkOutput("b2b period", 32'(cyc), (n == 0) ? 32'd9 : 32'd10);
      if (n < 999) begin
        ra   = 8'($urandom_range(0, 255));
        rb   = 8'($urandom_range(0, 255));
        rbin = 1'($urandom_range(0, 1));
        rexp = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
        bus.A   = ra;
        bus.B   = rb;
        bus.Bin = rbin;
        expq.push_back(rexp);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("b2b done count", 32'(doneCount - base), 32'd1000);
    checkOutput("b2b queue drained", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
